// File: rtl/cpu_sel_pkg.sv
// rtl/cpu_sel_pkg.sv - shared constants and helpers for the channel selector
package cpu_sel_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int DEF_WIDTH    = 32;

  // Width of an index able to address n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin / fixed-priority grant
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          fixed_prio_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;
  int             start;
  int             pos;

  // Rotate the doubled request vector so the search always starts at bit 0,
  // then map the first hit back to a channel index modulo N.
  always_comb begin
    dbl     = {req_i, req_i};
    start   = fixed_prio_i ? 0 : ((int'(last_i) + 1) % N);
    rot     = N'(dbl >> start);
    found   = 1'b0;
    pos     = 0;
    grant_o = '0;
    idx_o   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pos   = start + j;
        if (pos >= N) pos = pos - N;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (found && (pos == c)) grant_o[c] = 1'b1;
    end
    if (found) idx_o = IW'(pos);
  end

endmodule

// File: rtl/rr_data_selector.sv
// rtl/rr_data_selector.sv - N:1 valid/ready selector with registered output
module rr_data_selector
  import cpu_sel_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [CHANNELS*WIDTH-1:0]          In_Data,
  input  logic [CHANNELS-1:0]                In_Valid,
  output logic [CHANNELS-1:0]                In_Ready,
  input  logic                               Fixed_Prio,
  output logic [WIDTH-1:0]                   Out_Data,
  output logic [clog2_min1(CHANNELS)-1:0]    Out_Chan,
  output logic                               Out_Valid,
  input  logic                               Out_Ready
);

  localparam int CHAN_W = clog2_min1(CHANNELS);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [CHAN_W-1:0]   out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;
  logic [CHAN_W-1:0]   last_q, last_d;

  logic [CHANNELS-1:0] grant;
  logic [CHAN_W-1:0]   grant_idx;
  logic                load;
  logic                xfer;
  logic [WIDTH-1:0]    sel_data;

  rr_grant #(
    .N  (CHANNELS),
    .IW (CHAN_W)
  ) u_grant (
    .req_i        (In_Valid),
    .last_i       (last_q),
    .fixed_prio_i (Fixed_Prio),
    .grant_o      (grant),
    .idx_o        (grant_idx)
  );

  // The slot refills whenever it is empty or being drained this cycle.
  always_comb begin
    load     = !out_valid_q || Out_Ready;
    In_Ready = grant & {CHANNELS{load}};
    xfer     = |(In_Valid & In_Ready);
  end

  // AND-OR data mux over the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | (In_Data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Next state of the output slot and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load) begin
      if (xfer) begin
        out_data_d  = sel_data;
        out_chan_d  = grant_idx;
        out_valid_d = 1'b1;
        last_d      = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; pointer resets to the last channel so channel 0 leads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= CHAN_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign Out_Data  = out_data_q;
  assign Out_Chan  = out_chan_q;
  assign Out_Valid = out_valid_q;

endmodule

// File: tb/tb_rr_data_selector.sv
// tb/tb_rr_data_selector.sv - self-checking bench for rr_data_selector
module tb_rr_data_selector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         fixed_prio;
  logic [31:0]  out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  logic [7:0]   s_in_data;
  logic         s_in_valid;
  logic         s_in_ready;
  logic         s_fixed;
  logic [7:0]   s_out_data;
  logic         s_out_chan;
  logic         s_out_valid;
  logic         s_out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_chan;
  int          m_last;

  always #5 clk = ~clk;

  rr_data_selector #(.WIDTH(32), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .In_Data(in_data), .In_Valid(in_valid),
    .In_Ready(in_ready), .Fixed_Prio(fixed_prio), .Out_Data(out_data),
    .Out_Chan(out_chan), .Out_Valid(out_valid), .Out_Ready(out_ready)
  );

  rr_data_selector #(.WIDTH(8), .CHANNELS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .In_Data(s_in_data), .In_Valid(s_in_valid),
    .In_Ready(s_in_ready), .Fixed_Prio(s_fixed), .Out_Data(s_out_data),
    .Out_Chan(s_out_chan), .Out_Valid(s_out_valid), .Out_Ready(s_out_ready)
  );

  function automatic int model_grant(input logic [3:0] v, input logic fx, input int last);
    if (fx) begin
      for (int c = 0; c < 4; c++) if (v[c]) return c;
    end else begin
      for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant(in_valid, fixed_prio, m_last);
    if ((!m_valid || out_ready) && g >= 0) return 4'b0001 << g;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_last  = 3;
  endtask

  task automatic model_update();
    int g;
    if (!m_valid || out_ready) begin
      g = model_grant(in_valid, fixed_prio, m_last);
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = 32'(in_data >> (32 * g));
        m_chan  = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; fixed_prio = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0; s_fixed = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_errors++; $display("FAIL reset_data got %h want 0", out_data); end
    n_checks++; if (out_chan !== 2'd0) begin n_errors++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready got %b want 0000", in_ready); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL idle_ready got %b want 0000", in_ready); end
  endtask

  task automatic test_rr_sweep();
    in_data = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    in_valid = 4'b1111; out_ready = 1'b1; fixed_prio = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (in_ready !== (4'b0001 << (i % 4)) || in_ready !== model_ready()) begin
        n_errors++; $display("FAIL rr_ready[%0d] got %b want %b", i, in_ready, 4'b0001 << (i % 4));
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(i % 4) || out_data !== 32'hA0 + 32'(i % 4)) begin
        n_errors++;
        $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 i, out_valid, out_chan, out_data, i % 4, 32'hA0 + 32'(i % 4));
      end
    end
  endtask

  task automatic test_fixed_prio();
    fixed_prio = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 32'hA1) begin
        n_errors++; $display("FAIL fixed_out[%0d] got ch=%0d d=%h want ch=1 d=a1", i, out_chan, out_data);
      end
    end
    fixed_prio = 1'b0;
    #1;
    n_checks++; if (in_ready !== 4'b1000) begin n_errors++; $display("FAIL switch_ready got %b want 1000", in_ready); end
    tick();
    n_checks++;
    if (out_chan !== 2'd3 || out_data !== 32'hA3) begin
      n_errors++; $display("FAIL switch_out got ch=%0d d=%h want ch=3 d=a3", out_chan, out_data);
    end
  endtask

  task automatic test_back_pressure();
    in_data[64 +: 32] = 32'hDEAD_BEEF;
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    in_data = {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1, 32'h0000_00B0};
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_chan !== 2'd2) begin
        n_errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d want v=1 d=deadbeef ch=2", i, out_valid, out_data, out_chan);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b1000) begin n_errors++; $display("FAIL bp_release_ready got %b want 1000", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_data !== 32'hB3) begin
      n_errors++; $display("FAIL bp_release_out got ch=%0d d=%h want ch=3 d=b3", out_chan, out_data);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 4'b1111; out_ready = 1'b1; fixed_prio = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
      n_errors++; $display("FAIL async_reset got v=%b d=%h ch=%0d want 0/0/0", out_valid, out_data, out_chan);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++; if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL post_reset_ready got %b want 0001", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'hB0) begin
      n_errors++; $display("FAIL post_reset_out got v=%b ch=%0d d=%h want v=1 ch=0 d=b0", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [3:0] exp_rdy;
    pend = in_valid & ~model_ready();
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pend[c]) begin
          in_valid[c] = ($urandom_range(0, 2) != 0);
          in_data[c*32 +: 32] = $urandom;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) fixed_prio = ~fixed_prio;
      #1;
      assert ((in_valid & pend) == pend);
      exp_rdy = model_ready();
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_errors++; $display("FAIL rand_ready[%0d] got %b want %b", cyc, in_ready, exp_rdy);
      end
      pend = in_valid & ~exp_rdy;
      tick();
      n_checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_chan !== 2'(m_chan)))) begin
        n_errors++;
        $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                 cyc, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_single_channel();
    logic [7:0] exp_q[$];
    logic [7:0] want;
    int nsent;
    int nrecv;
    logic xin;
    logic xout;
    nsent = 0; nrecv = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (cyc < 60) begin
        s_out_ready = cyc[0];
        if (!s_in_valid && $urandom_range(0, 1) == 1) begin
          s_in_valid = 1'b1;
          s_in_data  = (nsent == 0) ? 8'h5A : 8'($urandom);
        end
      end else begin
        s_out_ready = 1'b1;
      end
      #1;
      xin  = s_in_valid && s_in_ready;
      xout = s_out_valid && s_out_ready;
      if (xout) begin
        nrecv++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (s_out_data !== want) begin n_errors++; $display("FAIL ch1_data[%0d] got %h want %h", nrecv, s_out_data, want); end
      end
      if (xin) begin
        exp_q.push_back(s_in_data);
        nsent++;
      end
      n_checks++; if (s_out_chan !== 1'b0) begin n_errors++; $display("FAIL ch1_chan got %b want 0", s_out_chan); end
      @(posedge clk);
      #1;
      if (xin) s_in_valid = 1'b0;
    end
    n_checks++;
    if (nrecv !== nsent || exp_q.size() != 0 || nsent < 5) begin
      n_errors++; $display("FAIL ch1_count got recv=%0d want sent=%0d", nrecv, nsent);
    end
  endtask

  initial begin
    test_reset();
    test_rr_sweep();
    test_fixed_prio();
    test_back_pressure();
    test_async_reset();
    test_random();
    test_single_channel();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_data_selector.md
Name: rr_data_selector

Overview:
- Parametrised successor to the 2:1 datapath selector: picks one of CHANNELS valid/ready source channels, each WIDTH bits wide, and drives a single registered output.
- Selection is round-robin by default. A fixed-priority mode is selectable at run time.
- Sits between multiple result/request producers (ALU, memory return, CP0, etc.) and a shared consumer such as the writeback or bus port.
- Adds one cycle of latency and keeps full throughput under back-pressure.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of source channels; legal range 1..16.
- CHAN_W, derived as max(1, clog2(CHANNELS)); width of the channel index. Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- In_Data  in  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- In_Valid  in  CHANNELS  per-channel data valid.
- In_Ready  out  CHANNELS  per-channel accept; combinational.
- Fixed_Prio  in  1  1 = fixed priority (channel 0 highest); 0 = round-robin.
- Out_Data  out  WIDTH  registered selected data.
- Out_Chan  out  CHAN_W  registered index of the channel that supplied Out_Data.
- Out_Valid  out  1  registered output valid.
- Out_Ready  in  1  consumer accept.

Behaviour:
- Reset, asynchronous on rst_n low:
  - Out_Valid=0, Out_Data=0, Out_Chan=0.
  - Round-robin pointer Last=CHANNELS-1, so channel 0 is first in priority after reset.
  - In_Ready follows combinationally; it is all-zero only because there are no grants during reset.
- Reset mid-transfer: any held Out_Data is discarded and is not replayed.
- Output slot can load: Load = !Out_Valid || Out_Ready.
- Grant, combinational, one-hot or zero:
  - Round-robin mode (Fixed_Prio=0): the first channel with In_Valid=1, searching Last+1, Last+2, … cyclically modulo CHANNELS.
  - Fixed-priority mode (Fixed_Prio=1): the lowest-index channel with In_Valid=1.
- In_Ready[i] = Grant[i] && Load. A transfer on channel i occurs when In_Valid[i] && In_Ready[i].
- On a clock edge with a transfer on channel g:
  - Out_Data <= channel g data; Out_Chan <= g; Out_Valid <= 1.
  - Last <= g. Last is updated in both modes so that switching mode is seamless.
- On a clock edge with Load=1 and no In_Valid: Out_Valid <= 0; Out_Data and Out_Chan hold their previous values.
- On a clock edge with Load=0 (Out_Valid && !Out_Ready): all output registers and Last hold. Out_Data must be stable while Out_Valid=1 && Out_Ready=0.
- Latency: a transfer at edge N makes the data visible at Out_* immediately after edge N.
- Throughput: one word per cycle while Out_Ready=1 continuously. Consumption and refill happen on the same edge.
- Fairness: with all channels valid continuously and Out_Ready=1, the grant order is 0,1,…,CHANNELS-1,0,…; no channel waits more than CHANNELS-1 transfers.
- Fixed_Prio may change on any cycle; it takes effect on that cycle's combinational grant.
- Sources must not retract In_Valid before their transfer. The block does not check this, but the bench asserts it.
- CHANNELS=1: the grant reduces to In_Valid[0] and Out_Chan is constant 0.
- No state machine beyond the output register and Last. No X on any output after reset.

Decomposition:
- Shared package cpu_sel_pkg:
  - function clog2_min1(n).
  - localparam constants MAX_CHANNELS=16 and DEF_WIDTH=32.
- One sub-module, rr_grant:
  - Inputs: request vector, Last, Fixed_Prio.
  - Outputs: one-hot grant and binary index.
  - Purely combinational, built on a doubled-vector priority search.
- The top level holds the output register, the Last register and the data mux (an AND-OR over one-hot grant, no priority chain).

Test Plan:
- Reset then idle: rst_n low for 3 cycles → Out_Valid=0, Out_Data=0, Out_Chan=0, In_Ready=4'b0000. After release with In_Valid=0 → still idle.
- Round-robin sweep:
  - Stimulus: In_Valid=4'b1111; data ch0..3 = 32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3; Out_Ready=1 for 8 cycles.
  - Required: Out_Chan sequence 0,1,2,3,0,1,2,3; Out_Data matches each channel; one word per cycle.
- Fixed priority: Fixed_Prio=1, In_Valid=4'b1010 held → Out_Chan=1 on every transfer; channel 3 is starved.
  - Then drop Fixed_Prio to 0 with Last=1 → next grant is ch3.
- Back-pressure hold: transfer 32'hDEAD_BEEF from ch2, then Out_Ready=0 for 5 cycles → Out_Valid=1, Out_Data=32'hDEAD_BEEF, Out_Chan=2 stable, In_Ready=0 throughout.
  - Then raise Out_Ready → next word loads on the same edge that consumes.
- Async reset mid-stream: assert rst_n low between clock edges while Out_Valid=1 → Out_Valid=0 immediately, without waiting for a clock edge. After release the first grant goes to ch0, not the pre-reset pointer.
- CHANNELS=1, WIDTH=8 instance: pulse In_Valid with 8'h5A while Out_Ready alternates 1/0 → every value delivered exactly once, in order, and Out_Chan=0 throughout.
